// File: rtl/handshake_pkg.sv
// Shared helpers for the handshake fabric: width helper and fan-out limit.
package handshake_pkg;

    localparam int unsigned MaxNumOuts = 16;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/handshake_token_counter.sv
// Data-less token FIFO: counts accepted control tokens and presents a head token.
module handshake_token_counter
    import handshake_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    output logic ready_o,
    input  logic all_done_i,
    output logic head_o,
    output logic pop_o
);

    if (Depth == 0) begin : gen_pass
        // No storage; the upstream token is the head and waits for every consumer.
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign head_o  = valid_i;
        assign ready_o = all_done_i;
        assign pop_o   = valid_i & all_done_i;
    end else begin : gen_buf
        localparam int unsigned CntW = clog2(Depth + 1);

        logic [CntW-1:0] cnt_q, cnt_d;
        logic            push;

        // Ready depends only on the count, which cuts the downstream ready path.
        assign head_o  = (cnt_q != '0);
        assign ready_o = (cnt_q != CntW'(Depth));
        assign push    = valid_i & ready_o;
        assign pop_o   = head_o & all_done_i;

        always_comb begin
            cnt_d = cnt_q;
            if (push && !pop_o) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (!push && pop_o) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

endmodule

// File: rtl/handshake_constant_fork_buf.sv
// Constant source: each control token yields one copy of ConstValue per output channel,
// delivered with eager-fork semantics behind an optional token buffer.
module handshake_constant_fork_buf
    import handshake_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter logic [63:0] ConstValue = 64'd0,
    parameter int unsigned NumOuts    = 1,
    parameter int unsigned Depth      = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ctrl_valid_i,
    output logic                 ctrl_ready_o,
    output logic [DataWidth-1:0] outs_o,
    output logic [NumOuts-1:0]   outs_valid_o,
    input  logic [NumOuts-1:0]   outs_ready_i
);

    logic [NumOuts-1:0] sent_q, sent_d;
    logic [NumOuts-1:0] done;
    logic               all_done;
    logic               head;
    logic               pop;

    assign outs_o = DataWidth'(ConstValue);

    handshake_token_counter #(
        .Depth (Depth)
    ) u_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (ctrl_valid_i),
        .ready_o    (ctrl_ready_o),
        .all_done_i (all_done),
        .head_o     (head),
        .pop_o      (pop)
    );

    // A channel that already took its copy counts as done and ignores its ready.
    always_comb begin
        outs_valid_o = {NumOuts{head}} & ~sent_q;
        done         = sent_q | outs_ready_i;
        all_done     = &done;
        if (pop) begin
            sent_d = '0;
        end else begin
            sent_d = sent_q | (outs_valid_o & outs_ready_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

endmodule

// File: tb/tb_handshake_constant_fork_buf.sv
// Directed bench with per-channel scoreboard queues for a buffered and an unbuffered instance.
module tb_handshake_constant_fork_buf;

    localparam logic [20:0] ConstA = 21'h0A9C77;
    localparam logic [7:0]  ConstB = 8'h5A;

    logic        clk;
    logic        rst_a, rst_b;
    logic        cv_a, cr_a, cv_b, cr_b;
    logic [20:0] outs_a;
    logic [7:0]  outs_b;
    logic [2:0]  ov_a, or_a;
    logic [1:0]  ov_b, or_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [20:0] q_a [3][$];
    logic [7:0]  q_b [2][$];

    handshake_constant_fork_buf #(
        .DataWidth  (21),
        .ConstValue (64'h0A9C77),
        .NumOuts    (3),
        .Depth      (2)
    ) dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_a),
        .ctrl_valid_i (cv_a),
        .ctrl_ready_o (cr_a),
        .outs_o       (outs_a),
        .outs_valid_o (ov_a),
        .outs_ready_i (or_a)
    );

    handshake_constant_fork_buf #(
        .DataWidth  (8),
        .ConstValue (64'h5A),
        .NumOuts    (2),
        .Depth      (0)
    ) dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_b),
        .ctrl_valid_i (cv_b),
        .ctrl_ready_o (cr_b),
        .outs_o       (outs_b),
        .outs_valid_o (ov_b),
        .outs_ready_i (or_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a();
        for (int i = 0; i < 3; i++) q_a[i].push_back(ConstA);
    endtask

    task automatic push_b();
        for (int i = 0; i < 2; i++) q_b[i].push_back(ConstB);
    endtask

    // Handshakes seen at the negedge complete on the following rising edge.
    always @(negedge clk) begin
        if (rst_a) begin
            for (int i = 0; i < 3; i++) begin
                if (ov_a[i] && or_a[i]) begin
                    if (q_a[i].size() == 0) chk("extra_copy_a", 64'(i), 64'hFF);
                    else chk("data_a", 64'(outs_a), 64'(q_a[i].pop_front()));
                end
            end
        end
        if (rst_b) begin
            for (int i = 0; i < 2; i++) begin
                if (ov_b[i] && or_b[i]) begin
                    if (q_b[i].size() == 0) chk("extra_copy_b", 64'(i), 64'hFF);
                    else chk("data_b", 64'(outs_b), 64'(q_b[i].pop_front()));
                end
            end
        end
    end

    initial begin
        logic [2:0] sk_rdy [5];
        logic [2:0] sk_val [5];
        logic       bp_cv  [8];
        logic [2:0] bp_rdy [8];
        logic       bp_cr  [8];
        logic [2:0] bp_val [8];
        logic       d0_cv  [3];
        logic [1:0] d0_rdy [3];
        logic [1:0] d0_val [3];
        logic       d0_cr  [3];

        sk_rdy = '{3'b000, 3'b001, 3'b100, 3'b010, 3'b000};
        sk_val = '{3'b000, 3'b111, 3'b110, 3'b010, 3'b000};
        bp_cv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bp_rdy = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111, 3'b000};
        bp_cr  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bp_val = '{3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
        d0_cv  = '{1'b1, 1'b1, 1'b0};
        d0_rdy = '{2'b10, 2'b01, 2'b00};
        d0_val = '{2'b11, 2'b01, 2'b00};
        d0_cr  = '{1'b0, 1'b1, 1'b0};

        // Reset with a token offered to the buffered instance.
        rst_a = 1'b0; rst_b = 1'b0;
        cv_a = 1'b1; cv_b = 1'b0;
        or_a = '0; or_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_a", 64'(ov_a), 64'd0);
        chk("rst_valid_b", 64'(ov_b), 64'd0);
        nxt();
        rst_a = 1'b1; rst_b = 1'b1; cv_a = 1'b0;
        @(negedge clk);
        chk("post_rst_ready_a", 64'(cr_a), 64'd1);
        chk("post_rst_valid_a", 64'(ov_a), 64'd0);
        chk("const_a", 64'(outs_a), 64'(ConstA));
        chk("const_b", 64'(outs_b), 64'(ConstB));

        // Streaming: 10 tokens, all consumers ready.
        for (int k = 0; k < 12; k++) begin
            nxt();
            cv_a = (k < 10);
            or_a = 3'b111;
            if (k < 10) push_a();
            @(negedge clk);
            chk("stream_valid", 64'(ov_a), (k >= 1 && k <= 10) ? 64'd7 : 64'd0);
            chk("stream_ready", 64'(cr_a), 64'd1);
        end

        // Eager fork with skewed readiness.
        for (int k = 0; k < 5; k++) begin
            nxt();
            cv_a = (k == 0);
            or_a = sk_rdy[k];
            if (k == 0) push_a();
            @(negedge clk);
            chk("skew_valid", 64'(ov_a), 64'(sk_val[k]));
        end

        // Backpressure until the buffer fills, then drain.
        for (int k = 0; k < 8; k++) begin
            nxt();
            cv_a = bp_cv[k];
            or_a = bp_rdy[k];
            if (bp_cv[k] && bp_cr[k]) push_a();
            @(negedge clk);
            chk("bp_ready", 64'(cr_a), 64'(bp_cr[k]));
            chk("bp_valid", 64'(ov_a), 64'(bp_val[k]));
        end

        // Unbuffered: ready follows completion of every channel combinationally.
        for (int k = 0; k < 3; k++) begin
            nxt();
            cv_b = d0_cv[k];
            or_b = d0_rdy[k];
            if (k == 0) push_b();
            @(negedge clk);
            chk("d0_valid", 64'(ov_b), 64'(d0_val[k]));
            chk("d0_ready", 64'(cr_b), 64'(d0_cr[k]));
        end

        // Reset while channel 1 still owes its copy.
        nxt();
        cv_b = 1'b1; or_b = 2'b01;
        push_b();
        @(negedge clk);
        chk("mid_valid0", 64'(ov_b), 64'd3);
        chk("mid_ready0", 64'(cr_b), 64'd0);
        nxt();
        or_b = 2'b00;
        @(negedge clk);
        chk("mid_valid1", 64'(ov_b), 64'd2);
        nxt();
        rst_b = 1'b0; cv_b = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(ov_b), 64'd0);
        q_b[1].delete();
        nxt();
        rst_b = 1'b1; cv_b = 1'b1; or_b = 2'b11;
        push_b();
        @(negedge clk);
        chk("after_rst_valid", 64'(ov_b), 64'd3);
        chk("after_rst_ready", 64'(cr_b), 64'd1);
        nxt();
        cv_b = 1'b0; or_b = 2'b00;
        @(negedge clk);
        chk("after_rst_idle", 64'(ov_b), 64'd0);

        for (int i = 0; i < 3; i++) chk("drain_a", 64'(q_a[i].size()), 64'd0);
        for (int i = 0; i < 2; i++) chk("drain_b", 64'(q_b[i].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
